// File: rtl/uc_booth_pkg.sv
// Shared types and constants for the Booth multiplier control unit.
package uc_booth_pkg;

    localparam int N_BITS_DEF = 3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        CHECK = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Booth decode of {q0, q_menos1}
    localparam logic [1:0] BOOTH_NOP0 = 2'b00;
    localparam logic [1:0] BOOTH_ADD  = 2'b01;
    localparam logic [1:0] BOOTH_SUB  = 2'b10;
    localparam logic [1:0] BOOTH_NOP1 = 2'b11;

endpackage

// File: rtl/uc_booth_contador_iter.sv
// Iteration down counter: synchronous load, decrement enable, flags the last iteration.
module contador_iter #(
    parameter int              W       = 2,
    parameter logic [W-1:0]    RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         carga,
    input  logic         dec,
    input  logic [W-1:0] valor,
    output logic         cero_sig
);

    logic [W-1:0] cuenta;

    // Never wraps below zero; load wins over decrement.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cuenta <= RST_VAL;
        end else if (carga) begin
            cuenta <= valor;
        end else if (dec && (cuenta != '0)) begin
            cuenta <= cuenta - W'(1);
        end
    end

    assign cero_sig = (cuenta == W'(1));

endmodule

// File: rtl/uc_booth.sv
// Control FSM for the signed Booth multiplier datapath (start/fin handshake).
module uc_booth
    import uc_booth_pkg::*;
#(
    parameter int N_BITS = N_BITS_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic q0,
    input  logic q_menos1,
    output logic Carga_A,
    output logic Resta,
    output logic Carga_QM,
    output logic Reset_A,
    output logic Desplaza_AQ,
    output logic ocupado,
    output logic fin
);

    localparam int             CW    = $clog2(N_BITS + 1);
    localparam logic [CW-1:0]  N_VAL = CW'(N_BITS);

    state_t state;
    state_t state_next;
    logic   ultima_iter;

    contador_iter #(
        .W       (CW),
        .RST_VAL (N_VAL)
    ) u_contador (
        .clk      (clk),
        .reset    (reset),
        .carga    (state == INIT),
        .dec      (state == SHIFT),
        .valor    (N_VAL),
        .cero_sig (ultima_iter)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = INIT;
            INIT:    state_next = CHECK;
            CHECK:   state_next = SHIFT;
            SHIFT:   state_next = ultima_iter ? DONE : CHECK;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Moore decode, except Carga_A/Resta in CHECK follow the Booth pair.
    always_comb begin
        Carga_A     = 1'b0;
        Resta       = 1'b0;
        Carga_QM    = 1'b0;
        Reset_A     = 1'b0;
        Desplaza_AQ = 1'b0;
        ocupado     = 1'b0;
        fin         = 1'b0;
        unique case (state)
            INIT: begin
                Carga_QM = 1'b1;
                Reset_A  = 1'b1;
                ocupado  = 1'b1;
            end
            CHECK: begin
                ocupado = 1'b1;
                case ({q0, q_menos1})
                    BOOTH_SUB: begin
                        Carga_A = 1'b1;
                        Resta   = 1'b1;
                    end
                    BOOTH_ADD: Carga_A = 1'b1;
                    default: ;
                endcase
            end
            SHIFT: begin
                Desplaza_AQ = 1'b1;
                ocupado     = 1'b1;
            end
            DONE:    fin = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_uc_booth.sv
// Bench for uc_booth with a behavioural Booth datapath and a fin-driven scoreboard.
module tb_uc_booth;

    logic clk = 1'b0;
    logic reset, start;
    logic q0, q_menos1;
    logic Carga_A, Resta, Carga_QM, Reset_A, Desplaza_AQ, ocupado, fin;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fin_cnt = 0, qm_cnt = 0, add_cnt = 0, sub_cnt = 0;

    logic [3:0] a_reg = '0, m_reg = '0;
    logic [2:0] q_reg = '0, mcand = '0, mplier = '0;
    logic       qm1_reg = 1'b0;
    logic       force_q = 1'b0, fq0 = 1'b0, fqm1 = 1'b0;
    logic [5:0] result;

    typedef struct {
        int         exp_cyc;
        logic       chk_res;
        logic [5:0] exp_res;
    } exp_t;
    exp_t sb[$];

    uc_booth dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .q0          (q0),
        .q_menos1    (q_menos1),
        .Carga_A     (Carga_A),
        .Resta       (Resta),
        .Carga_QM    (Carga_QM),
        .Reset_A     (Reset_A),
        .Desplaza_AQ (Desplaza_AQ),
        .ocupado     (ocupado),
        .fin         (fin)
    );

    always #5 clk = ~clk;

    // Behavioural datapath; A carries one guard bit so a -4 multiplicand cannot overflow.
    initial forever begin
        @(posedge clk);
        cyc++;
        if (Carga_QM) begin
            m_reg   <= {mcand[2], mcand};
            q_reg   <= mplier;
            qm1_reg <= 1'b0;
        end
        if (Reset_A) a_reg <= '0;
        if (Carga_A) a_reg <= Resta ? a_reg - m_reg : a_reg + m_reg;
        if (Desplaza_AQ) begin
            a_reg   <= {a_reg[3], a_reg[3:1]};
            q_reg   <= {a_reg[0], q_reg[2:1]};
            qm1_reg <= q_reg[0];
        end
    end

    assign q0       = force_q ? fq0  : q_reg[0];
    assign q_menos1 = force_q ? fqm1 : qm1_reg;
    assign result   = {a_reg[2:0], q_reg};

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] outs();
        return {Carga_A, Resta, Carga_QM, Reset_A, Desplaza_AQ, ocupado, fin};
    endfunction

    // Monitor: pops the scoreboard on every fin and watches control invariants.
    initial begin
        logic prev_fin;
        exp_t e;
        prev_fin = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (Carga_QM) qm_cnt++;
                if (Carga_A && Resta) sub_cnt++;
                if (Carga_A && !Resta) add_cnt++;
                checkOutput("exclusive", 32'(Carga_A + Carga_QM + Desplaza_AQ > 1 || (Resta && !Carga_A)), 0);
                if (fin) begin
                    fin_cnt++;
                    checkOutput("fin_one_cycle", 32'(prev_fin), 0);
                    if (sb.size() == 0) begin
                        checkOutput("unexpected_fin", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        checkOutput("fin_cycle", cyc, e.exp_cyc);
                        if (e.chk_res) checkOutput("result", 32'(result), 32'(e.exp_res));
                    end
                end
                prev_fin = fin;
            end else begin
                prev_fin = 1'b0;
            end
        end
    end

    // Issues one start; the start edge becomes edge 0 and fin is due 7 edges later.
    task automatic applyStimulus(input logic [2:0] mc, input logic [2:0] mp, input logic fq,
                                 input logic [1:0] code, input logic push,
                                 input logic chk, input logic [5:0] exp_res);
        exp_t e;
        mcand   = mc;
        mplier  = mp;
        force_q = fq;
        {fq0, fqm1} = code;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (push) begin
            e.exp_cyc = cyc + 7;
            e.chk_res = chk;
            e.exp_res = exp_res;
            sb.push_back(e);
        end
    endtask

    task automatic waitDone(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() != 0) begin
            checkOutput("timeout", sb.size(), 0);
            sb.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int f0, q0c, a0, s0, s;
        logic [1:0] codes [4];
        logic [1:0] exp_ar [4];
        codes  = '{2'b10, 2'b01, 2'b00, 2'b11};
        exp_ar = '{2'b11, 2'b10, 2'b00, 2'b00};

        reset = 1'b0;
        start = 1'b0;
        #12;
        checkOutput("reset_outputs", 32'(outs()), 0);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("idle_outputs", 32'(outs()), 0);

        $display("[TB] 3 x 2");
        applyStimulus(3'b011, 3'b010, 1'b0, 2'b00, 1'b1, 1'b1, 6'b000110);
        waitDone(20);

        $display("[TB] -4 x 3");
        a0 = add_cnt; s0 = sub_cnt;
        applyStimulus(3'b100, 3'b011, 1'b0, 2'b00, 1'b1, 1'b1, 6'b110100);
        waitDone(20);
        checkOutput("sub_count", sub_cnt - s0, 1);
        checkOutput("add_count", add_cnt - a0, 1);

        $display("[TB] forced Booth codes");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(3'b000, 3'b000, 1'b1, codes[i], 1'b1, 1'b0, 6'b0);
            @(posedge clk); #1;
            checkOutput("check_carga_resta", 32'({Carga_A, Resta}), 32'(exp_ar[i]));
            checkOutput("check_no_shift", 32'(Desplaza_AQ), 0);
            @(posedge clk); #1;
            checkOutput("shift_after_check", 32'({Desplaza_AQ, Carga_A}), 32'b10);
            waitDone(20);
        end
        force_q = 1'b0;

        $display("[TB] reset during SHIFT of iteration 2");
        f0 = fin_cnt;
        applyStimulus(3'b011, 3'b010, 1'b0, 2'b00, 1'b0, 1'b0, 6'b0);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("pre_reset_shift", 32'(Desplaza_AQ), 1);
        #2 reset = 1'b0;
        #1;
        checkOutput("async_reset_outputs", 32'(outs()), 0);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("aborted_no_fin", fin_cnt - f0, 0);
        applyStimulus(3'b011, 3'b010, 1'b0, 2'b00, 1'b1, 1'b1, 6'b000110);
        waitDone(20);

        $display("[TB] start held high");
        f0 = fin_cnt; q0c = qm_cnt;
        mcand = 3'b011; mplier = 3'b010;
        start = 1'b1;
        @(posedge clk); #1;
        s = cyc;
        for (int k = 0; k < 3; k++) begin
            exp_t e;
            e.exp_cyc = s + 7 + 9 * k;
            e.chk_res = 1'b1;
            e.exp_res = 6'b000110;
            sb.push_back(e);
        end
        repeat (8) @(posedge clk);
        #1;
        checkOutput("ocupado_idle_gap", 32'({ocupado, Carga_QM}), 0);
        repeat (11) @(posedge clk);
        #1;
        start = 1'b0;
        waitDone(30);
        checkOutput("held_fin_count", fin_cnt - f0, 3);
        checkOutput("held_qm_count", qm_cnt - q0c, 3);

        $display("[TB] start pulse during CHECK");
        f0 = fin_cnt; q0c = qm_cnt;
        applyStimulus(3'b011, 3'b010, 1'b0, 2'b00, 1'b1, 1'b1, 6'b000110);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        waitDone(20);
        repeat (12) @(posedge clk);
        #1;
        checkOutput("pulse_fin_count", fin_cnt - f0, 1);
        checkOutput("pulse_qm_count", qm_cnt - q0c, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
